// File: rtl/cond_eval.sv
// Condition-code evaluator: decodes {Z,N,V,C} + cond into one result bit and buffers results in a 2-entry FIFO.
// Optional saturating true-result counter on hit_count when COND_EVAL_COUNT_EN is defined.
module cond_eval
`ifdef COND_EVAL_COUNT_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Z,
  input  logic             N,
  input  logic             V,
  input  logic             C,
  input  logic [3:0]       cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result
`ifdef COND_EVAL_COUNT_EN
  ,
  output logic [CNT_W-1:0] hit_count
`endif
);

  logic       r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_cnt;

  logic w_eval;
  logic w_push;
  logic w_pop;
  logic w_head;

  always_comb begin
    w_eval = 1'b0;
    case (cond)
      4'd0:  w_eval = Z;
      4'd1:  w_eval = ~Z;
      4'd2:  w_eval = C;
      4'd3:  w_eval = ~C;
      4'd4:  w_eval = N;
      4'd5:  w_eval = ~N;
      4'd6:  w_eval = V;
      4'd7:  w_eval = ~V;
      4'd8:  w_eval = C & ~Z;
      4'd9:  w_eval = ~C | Z;
      4'd10: w_eval = N ~^ V;
      4'd11: w_eval = N ^ V;
      4'd12: w_eval = ~Z & (N ~^ V);
      4'd13: w_eval = Z | (N ^ V);
      4'd14: w_eval = 1'b1;
      4'd15: w_eval = 1'b0;
      default: w_eval = 1'b0;
    endcase
  end

  // in_ready comes only from registered occupancy, so a pop never frees a slot in the same cycle
  assign in_ready  = (r_cnt != 2'd2);
  assign out_valid = (r_cnt != 2'd0);
  assign w_head    = r_mem[r_rptr];
  assign result    = out_valid & w_head;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= 1'b0;
      r_mem[1] <= 1'b0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_eval;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef COND_EVAL_COUNT_EN
  logic [CNT_W-1:0] r_hits;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hits <= '0;
    end else if (w_pop && w_head && (r_hits != {CNT_W{1'b1}})) begin
      r_hits <= r_hits + 1'b1;
    end
  end

  assign hit_count = r_hits;
`endif

endmodule

// File: tb/tb_cond_eval.sv
// Self-checking bench for cond_eval: directed steps plus random traffic against a queue-based reference model.
module tb_cond_eval;

  localparam int TB_CNT_W = 2;
  localparam int HIT_MAX  = (1 << TB_CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       z = 1'b0, n = 1'b0, v = 1'b0, c = 1'b0;
  logic [3:0] cond = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       result;
`ifdef COND_EVAL_COUNT_EN
  logic [TB_CNT_W-1:0] hit_count;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  bit q[$];
  int hits = 0;

`ifdef COND_EVAL_COUNT_EN
  cond_eval #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Z(z), .N(n), .V(v), .C(c), .cond(cond),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .hit_count(hit_count)
  );
`else
  cond_eval dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Z(z), .N(n), .V(v), .C(c), .cond(cond),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );
`endif

  always #5 clk = ~clk;

  // Pairs of conditions are complements; the odd member inverts the even one.
  function automatic bit ref_cond(input int sel, input bit fz, input bit fn, input bit fv, input bit fc);
    bit base;
    bit sgn_ge;
    sgn_ge = (fn == fv);
    case (sel / 2)
      0: base = fz;
      1: base = fc;
      2: base = fn;
      3: base = fv;
      4: base = fc && !fz;
      5: base = sgn_ge;
      6: base = !fz && sgn_ge;
      default: base = 1'b1;
    endcase
    return (sel % 2 == 1) ? !base : base;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
    chk({tag, ".result"},    32'(result),    32'((q.size() != 0) ? q[0] : 1'b0));
`ifdef COND_EVAL_COUNT_EN
    chk({tag, ".hit_count"}, 32'(hit_count), 32'(hits));
`endif
  endtask

  // One clock: drive at negedge, predict handshakes from the model, advance, check at next negedge.
  task automatic cycle(input string tag, input bit iv, input int sel,
                       input bit fz, input bit fn, input bit fv, input bit fc, input bit ordy);
    bit acc, pop, val;
    in_valid  = iv;
    cond      = 4'(sel);
    z = fz; n = fn; v = fv; c = fc;
    out_ready = ordy;
    acc = iv && (q.size() < 2);
    pop = (q.size() != 0) && ordy;
    val = ref_cond(sel, fz, fn, fv, fc);
    @(posedge clk);
    if (pop) begin
      if (q[0] && hits < HIT_MAX) hits++;
      void'(q.pop_front());
    end
    if (acc) q.push_back(val);
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    q.delete();
    hits = 0;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_state("reset");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.result",    32'(result),    32'd0);

    // Full decode sweep, streamed with out_ready high
    for (int s = 0; s < 16; s++)
      for (int f = 0; f < 16; f++)
        cycle("sweep", 1'b1, s, f[3], f[2], f[1], f[0], 1'b1);
    cycle("drain", 1'b0, 0, 0, 0, 0, 0, 1'b1);

    // Directed examples checked against fixed values
    cycle("ex_gt", 1'b1, 12, 0, 1, 1, 0, 1'b0);
    chk("ex_gt.value", 32'(result), 32'd1);
    cycle("ex_ls", 1'b1, 9, 0, 0, 0, 1, 1'b1);
    chk("ex_ls.value", 32'(result), 32'd0);
    cycle("drain", 1'b0, 0, 0, 0, 0, 0, 1'b1);

    // Latency/throughput: EQ with Z = 1,0,1,0
    cycle("lat", 1'b1, 0, 1, 0, 0, 0, 1'b1);
    chk("lat.first", 32'(result), 32'd1);
    cycle("lat", 1'b1, 0, 0, 0, 0, 0, 1'b1);
    cycle("lat", 1'b1, 0, 1, 0, 0, 0, 1'b1);
    cycle("lat", 1'b1, 0, 0, 0, 0, 0, 1'b1);
    cycle("lat", 1'b0, 0, 0, 0, 0, 0, 1'b1);

    // Back-pressure: three offers, two accepted, third lands after first pop
    cycle("bp", 1'b1, 14, 0, 0, 0, 0, 1'b0);
    cycle("bp", 1'b1, 15, 0, 0, 0, 0, 1'b0);
    chk("bp.full", 32'(in_ready), 32'd0);
    cycle("bp", 1'b1, 0, 1, 0, 0, 0, 1'b0);
    cycle("bp", 1'b1, 0, 1, 0, 0, 0, 1'b1);
    cycle("bp", 1'b1, 0, 1, 0, 0, 0, 1'b1);
    cycle("bp", 1'b0, 0, 0, 0, 0, 0, 1'b1);
    cycle("bp", 1'b0, 0, 0, 0, 0, 0, 1'b1);
    cycle("bp", 1'b0, 0, 0, 0, 0, 0, 1'b1);

    // Simultaneous push/pop at one entry
    cycle("pp", 1'b1, 14, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      cycle("pp", 1'b1, (i % 2) ? 15 : 14, 0, 0, 0, 0, 1'b1);
    cycle("pp", 1'b0, 0, 0, 0, 0, 0, 1'b1);

    // Reset mid-stream with two entries held
    cycle("fill", 1'b1, 14, 0, 0, 0, 0, 1'b0);
    cycle("fill", 1'b1, 14, 0, 0, 0, 0, 1'b0);
    do_reset();
    chk("rst2.out_valid", 32'(out_valid), 32'd0);
    chk("rst2.in_ready",  32'(in_ready),  32'd1);
    cycle("post_rst", 1'b0, 0, 0, 0, 0, 0, 1'b1);

    // Counter: five true pops with stalls and false results mixed in
    for (int i = 0; i < 5; i++) begin
      cycle("cnt", 1'b1, 14, 0, 0, 0, 0, 1'b0);
      cycle("cnt", 1'b0, 0, 0, 0, 0, 0, 1'b0);
      cycle("cnt", 1'b0, 0, 0, 0, 0, 0, 1'b1);
      cycle("cnt", 1'b1, 15, 0, 0, 0, 0, 1'b1);
      cycle("cnt", 1'b0, 0, 0, 0, 0, 0, 1'b1);
    end
`ifdef COND_EVAL_COUNT_EN
    chk("cnt.sat", 32'(hit_count), 32'(HIT_MAX));
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      automatic int r = int'($urandom);
      cycle("rand", r[0], r[7:4], r[8], r[9], r[10], r[11], r[12] | r[13]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_eval.md
# cond_eval

Condition-code evaluator at the consuming end of the subtract-based comparator's flag interface. It accepts a stream of {Z, N, V, C} flag tuples plus a 4-bit condition selector over a valid/ready handshake. It decodes each tuple into a single true/false relation (signed, unsigned, or raw-flag) and returns results in order through a 2-entry buffered output handshake. It sits between the comparator datapath and branch/select control logic.

## Interface
- `CNT_W`, 16, width of the true-result counter (only with `COND_EVAL_COUNT_EN`).
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  flag tuple and selector present.
- `in_ready`  output  1  block can accept a tuple this cycle.
- `Z`  input  1  comparator zero flag (x−y == 0).
- `N`  input  1  comparator negative flag (MSB of x−y).
- `V`  input  1  comparator signed-overflow flag.
- `C`  input  1  comparator carry-out (1 means x ≥ y unsigned).
- `cond`  input  4  condition selector.
- `out_valid`  output  1  `result` valid.
- `out_ready`  input  1  consumer accepts `result`.
- `result`  output  1  evaluated condition.
- `hit_count`  output  CNT_W  saturating count of accepted true results (only with `COND_EVAL_COUNT_EN`).

## Operation
- Condition decode, with `cond` values listed in order 0–15:
  - 0 EQ: Z
  - 1 NE: ~Z
  - 2 HS: C
  - 3 LO: ~C
  - 4 MI: N
  - 5 PL: ~N
  - 6 VS: V
  - 7 VC: ~V
  - 8 HI: C&~Z
  - 9 LS: ~C|Z
  - 10 GE: N~^V
  - 11 LT: N^V
  - 12 GT: ~Z&(N~^V)
  - 13 LE: Z|(N^V)
  - 14 AL: 1
  - 15 NV: 0
- Evaluation happens at input acceptance. Only the 1-bit result is stored; the flags are not.
- Storage is a 2-entry in-order FIFO of result bits, with write pointer, read pointer and 2-bit occupancy `cnt`.
- Input handshake:
  - Accept when `in_valid && in_ready`.
  - `in_ready = (cnt != 2)`. It depends only on registered state, never combinationally on `out_ready`.
- Output handshake:
  - Pop when `out_valid && out_ready`.
  - `out_valid = (cnt != 0)`.
  - `result` = head entry. It is held stable while `out_valid && !out_ready`.
- Occupancy update per cycle:
  - Push only: cnt+1.
  - Pop only: cnt−1.
  - Push and pop together (possible only at cnt==1): cnt unchanged, new entry written behind head.
- Pointers are 1-bit and wrap 1→0.
- Inputs are ignored when `in_valid=0`. `cond` and flags are don't-care then.
- `result` is 0 when `out_valid=0`.
- State "empty" (cnt 0):
  - Push → one entry.
- State "one entry" (cnt 1):
  - Push only → full.
  - Pop only → empty.
  - Push and pop → stays at one entry.
- State "full" (cnt 2):
  - `in_ready=0`.
  - Pop → one entry.
  - Even when a pop occurs, no push is accepted in the same cycle.

## Timing
- Latency: a tuple accepted at edge k gives `out_valid=1` with its `result` visible after edge k, meaning the next cycle, when the FIFO was empty.
- Throughput: one result per cycle sustained when `out_ready` is held high.
- Full back-pressure:
  - Two accepted tuples with `out_ready=0` drive `in_ready` low after the second edge.
  - `in_ready` rises the cycle after the first pop.
- Reset values: cnt=0, pointers=0, `out_valid=0`, `in_ready=1`, `result=0`, `hit_count=0`.
- Reset mid-operation discards all buffered results without emitting them. `rst` dominates any concurrent handshake.

## Configuration
- Macro `COND_EVAL_COUNT_EN`.
- Defined:
  - `hit_count` port and counter exist.
  - The counter increments by 1 on each output pop with `result=1`.
  - It saturates at 2^CNT_W−1 and never wraps.
  - It clears only on `rst`.
- Undefined:
  - No counter logic and no `hit_count` port.
  - Handshake and result behaviour are otherwise identical.

## Test plan
- Full decode sweep:
  - For each of 16 `cond` × 16 flag combinations, send the tuple with `out_ready=1`.
  - Each `result` equals the table.
  - Example: cond=12, Z=0, N=1, V=1 → 1.
  - Example: cond=9, C=1, Z=0 → 0.
- Latency and throughput:
  - Stream cond=0 with Z=1,0,1,0 on consecutive cycles, `out_ready=1`.
  - Results 1,0,1,0 appear one cycle later with `out_valid` continuously 1.
- Back-pressure:
  - Hold `out_ready=0` and offer 3 tuples.
  - Only 2 are accepted and `in_ready=0`.
  - Raise `out_ready`: results pop in order, and the third tuple is accepted the cycle after the first pop.
- Simultaneous push/pop at cnt=1: occupancy stays 1 and ordering is preserved.
- Reset mid-stream:
  - Fill 2 entries, then assert `rst` one cycle.
  - Next cycle `out_valid=0`, `in_ready=1`, no stale results are emitted, and `hit_count=0`.
- Counter (macro defined, CNT_W=2):
  - Pop 5 true results → `hit_count` goes 1,2,3,3,3.
  - False results and `out_ready=0` stalls do not increment it.
